// File: rtl/fir_sample_capture_pkg.sv
// Shared types and constants for the FIR output capture path.
// Sample width and orientation must track the FIR filter output.
package fir_sample_capture_pkg;

   localparam int SAMPLE_W      = 16;
   localparam int CAPTURE_DEPTH = 16;

   // Bit 0 is the MSB, matching the filter's bit ordering.
   typedef logic [0:SAMPLE_W-1] sample_t;

endpackage

// File: rtl/fir_sample_capture_sample_ram.sv
// Simple dual-port sample store: synchronous write, registered read.
// Written so it maps onto block RAM or distributed RAM.
module sample_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [0:DATA_W-1] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [0:DATA_W-1] o_rdata
);

   logic [0:DATA_W-1] r_mem [DEPTH];
   logic [0:DATA_W-1] r_rdata;

   // Read-first: a read and write to the same slot on one edge returns the old word.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/fir_sample_capture.sv
// Circular capture buffer for the FIR output stream with a one-cycle
// request/valid read port and a sticky overrun flag.
module fir_sample_capture
   import fir_sample_capture_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int DEPTH  = CAPTURE_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              Data_valid,
   input  logic [0:DATA_W-1] DataOut,
   input  logic              rd_req,
   output logic [0:DATA_W-1] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_empty;
   logic              r_full;
   logic              r_rd_valid;
   logic              r_overflow;
   logic              r_rd_zero;

   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_drop;
   logic [ADDR_W:0]   w_count_nxt;
   logic [0:DATA_W-1] w_ram_rdata;

   // Read handshake: rd_req is accepted on an edge where empty=0; the sample
   // appears on rd_data with rd_valid high for exactly the next cycle. There is
   // no back-pressure, and a request while empty is silently ignored.
   assign w_rd_acc = RSTn & rd_req & ~r_empty;
   assign w_wr_acc = RSTn & Data_valid & (~r_full | w_rd_acc);
   assign w_drop   = Data_valid & r_full & ~w_rd_acc;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + CNT_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
         w_count_nxt = r_count - CNT_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_overflow <= 1'b0;
         r_rd_zero  <= 1'b1;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            r_rd_zero <= 1'b0;
         end
         r_count    <= w_count_nxt;
         r_empty    <= (w_count_nxt == '0);
         r_full     <= (w_count_nxt == CNT_FULL);
         r_rd_valid <= w_rd_acc;
         // A drop on the same edge as clr_ovf keeps the flag set.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   sample_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_sample_ram (
      .i_clk   (CLK),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (DataOut),
      .i_re    (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_ram_rdata)
   );

   // The RAM read register has no reset, so mask it until the first read after reset.
   assign rd_data  = r_rd_zero ? '0 : w_ram_rdata;
   assign rd_valid = r_rd_valid;
   assign empty    = r_empty;
   assign full     = r_full;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_fir_sample_capture.sv
// Bench for fir_sample_capture: queue-based reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_fir_sample_capture;

   localparam int DEPTH = 16;

   logic        CLK;
   logic        RSTn;
   logic        Data_valid;
   logic [0:15] DataOut;
   logic        rd_req;
   logic [0:15] rd_data;
   logic        rd_valid;
   logic        empty;
   logic        full;
   logic [4:0]  count;
   logic        overflow;
   logic        clr_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [15:0] exp_q[$];
   logic        m_rdv = 1'b0;
   logic [15:0] m_rdd = 16'h0000;
   logic        m_ovf = 1'b0;

   fir_sample_capture dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Data_valid (Data_valid),
      .DataOut    (DataOut),
      .rd_req     (rd_req),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      RSTn       = 1'b0;
      Data_valid = 1'b0;
      DataOut    = '0;
      rd_req     = 1'b0;
      clr_ovf    = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model update at each edge, compare just after it
   initial begin
      logic rd, wr;
      forever begin
         @(posedge CLK);
         if (!RSTn) begin
            exp_q.delete();
            m_rdv = 1'b0;
            m_rdd = 16'h0000;
            m_ovf = 1'b0;
         end else begin
            rd = rd_req && (exp_q.size() > 0);
            wr = Data_valid && ((exp_q.size() < DEPTH) || rd);
            m_rdv = rd;
            if (rd) m_rdd = exp_q.pop_front();
            if (wr) exp_q.push_back(DataOut);
            if (Data_valid && !wr) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
         end
         #1;
         check("m_count",    32'(count),    32'(exp_q.size()));
         check("m_empty",    32'(empty),    32'(exp_q.size() == 0));
         check("m_full",     32'(full),     32'(exp_q.size() == DEPTH));
         check("m_rd_valid", 32'(rd_valid), 32'(m_rdv));
         check("m_rd_data",  32'(rd_data),  32'(m_rdd));
         check("m_overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   // driver: apply inputs at negedge, return just after the next rising edge
   task automatic cyc(input logic rst_n, input logic dv, input logic [15:0] d,
                      input logic rq, input logic clr);
      @(negedge CLK);
      RSTn       = rst_n;
      Data_valid = dv;
      DataOut    = d;
      rd_req     = rq;
      clr_ovf    = clr;
      @(posedge CLK);
      #2;
   endtask

   logic [15:0] t2_vec [3] = '{16'h1234, 16'hABCD, 16'h8001};

   initial begin
      // reset then idle reads
      cyc(0, 0, 16'h0, 0, 0);
      cyc(0, 0, 16'h0, 0, 0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full",  32'(full),  32'd0);
      check("rst_rdata", 32'(rd_data), 32'h0);
      repeat (3) begin
         cyc(1, 0, 16'h0, 1, 0);
         check("idle_rd_valid", 32'(rd_valid), 32'd0);
         check("idle_rdata",    32'(rd_data),  32'h0);
      end
      check("idle_empty", 32'(empty), 32'd1);

      // three writes then three reads
      for (int i = 0; i < 3; i++) cyc(1, 1, t2_vec[i], 0, 0);
      check("t2_count", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 16'h0, 1, 0);
         check("t2_rd_valid", 32'(rd_valid), 32'd1);
         check("t2_rdata",    32'(rd_data),  32'(t2_vec[i]));
         check("t2_count",    32'(count),    32'(2 - i));
      end
      check("t2_empty", 32'(empty), 32'd1);

      // 17 writes, no reads
      for (int i = 0; i < 17; i++) begin
         cyc(1, 1, 16'(i), 0, 0);
         if (i == 15) begin
            check("t3_full16", 32'(full),     32'd1);
            check("t3_ovf16",  32'(overflow), 32'd0);
         end
      end
      check("t3_ovf17",   32'(overflow), 32'd1);
      check("t3_count17", 32'(count),    32'd16);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 16'h0, 1, 0);
         check("t3_rdata", 32'(rd_data), 32'(i));
      end
      cyc(1, 0, 16'h0, 1, 0);
      check("t3_no_extra", 32'(rd_valid), 32'd0);
      check("t3_empty",    32'(empty),    32'd1);

      // full with simultaneous read and write
      cyc(1, 0, 16'h0, 0, 1);
      check("t4_clr", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) cyc(1, 1, 16'(16'h0100 + i), 0, 0);
      check("t4_full", 32'(full), 32'd1);
      cyc(1, 1, 16'h5555, 1, 0);
      check("t4_ovf",   32'(overflow), 32'd0);
      check("t4_count", 32'(count),    32'd16);
      check("t4_rdata", 32'(rd_data),  32'h0100);
      for (int i = 0; i < 15; i++) begin
         cyc(1, 0, 16'h0, 1, 0);
         check("t4_drain", 32'(rd_data), 32'(16'h0101 + i));
      end
      cyc(1, 0, 16'h0, 1, 0);
      check("t4_last", 32'(rd_data), 32'h5555);
      check("t4_empty", 32'(empty), 32'd1);

      // sustained write+read at count=2 across pointer wrap
      cyc(1, 1, 16'h0200, 0, 0);
      cyc(1, 1, 16'h0201, 0, 0);
      for (int i = 0; i < 40; i++) begin
         cyc(1, 1, 16'(16'h0300 + i), 1, 0);
         check("t5_rdata", 32'(rd_data),
               (i < 2) ? 32'(16'h0200 + i) : 32'(16'h0300 + i - 2));
         check("t5_count", 32'(count),    32'd2);
         check("t5_ovf",   32'(overflow), 32'd0);
      end

      // overflow set wins over clear
      for (int i = 0; i < 14; i++) cyc(1, 1, 16'(16'h0400 + i), 0, 0);
      check("t6_full", 32'(full), 32'd1);
      cyc(1, 1, 16'hDEAD, 0, 0);
      check("t6_ovf_set", 32'(overflow), 32'd1);
      cyc(1, 1, 16'hBEEF, 0, 1);
      check("t6_set_wins", 32'(overflow), 32'd1);
      cyc(1, 0, 16'h0, 0, 1);
      check("t6_clr", 32'(overflow), 32'd0);
      check("t6_count", 32'(count), 32'd16);

      // reset mid-stream
      cyc(0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 16'(16'h0500 + i), 0, 0);
      check("t7_count5", 32'(count), 32'd5);
      cyc(0, 1, 16'h0777, 1, 0);
      check("t7_count", 32'(count),    32'd0);
      check("t7_empty", 32'(empty),    32'd1);
      check("t7_rdv",   32'(rd_valid), 32'd0);
      check("t7_rdata", 32'(rd_data),  32'h0);
      cyc(1, 0, 16'h0, 1, 0);
      check("t7_ignored_wr", 32'(rd_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_sample_capture.md
Name: fir_sample_capture

Overview:
- Receiving end of the FIR filter's output stream.
- Accepts each qualified 16-bit filtered sample (`DataOut` strobed by `Data_valid`) into a circular buffer.
- Presents samples in arrival order to a downstream consumer (DAC driver, UART dumper, checker) over a request/valid read handshake.
- Flags samples lost on overrun, so audio-path throughput problems show up in hardware and not only in simulation.

Parameters:
- DATA_W, 16, sample width; matches the FIR filter output width.
- DEPTH, 16, buffer entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTn  in  1  synchronous active-low reset.
- Data_valid  in  1  write strobe from the FIR filter; one sample per high cycle.
- DataOut  in  [0:DATA_W-1]  filtered sample; bit 0 is MSB (filter's bit ordering).
- rd_req  in  1  consumer requests one sample this cycle.
- rd_data  out  [0:DATA_W-1]  registered read sample; bit 0 is MSB.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; at least one sample was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Single clock, CLK. Reset is synchronous, active-low (RSTn sampled on CLK rising edge). No asynchronous paths.
- Values during RSTn=0 at the edge:
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_data=0, rd_valid=0, overflow=0.
  - empty=1, full=0.
  - Buffer contents are not cleared.
- Reset mid-operation discards all stored samples. Inputs are ignored in the reset cycle.
- Write accepted when `Data_valid=1` and (`full=0` or a read is accepted the same cycle):
  - mem[wr_ptr] <= DataOut.
  - wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- Write dropped when `Data_valid=1`, `full=1` and no read is accepted: buffer unchanged, overflow <= 1.
- Read accepted when `rd_req=1` and `empty=0`:
  - rd_data <= mem[rd_ptr] on that edge.
  - rd_valid=1 for the following cycle only.
  - rd_ptr increments modulo DEPTH.
  - Read latency is one cycle.
- `rd_req` while empty is ignored: rd_valid=0, rd_data holds its last value. No write-to-read bypass.
- Simultaneous events:
  - Read and write, 0<count<DEPTH: both accepted, count unchanged.
  - Read and write, full: both accepted, the freed slot takes the new sample, no overflow, count stays DEPTH.
  - Read and write, empty: write accepted, read ignored, count becomes 1, rd_valid=0.
  - clr_ovf in the same cycle as a dropped write: set wins, overflow stays 1.
- count, empty and full are registered and reflect the state after the edge. The first write makes empty=0 one cycle after the Data_valid cycle.
- Back-to-back: one write and one read per cycle, sustained indefinitely with no loss.
- Data is passed through unmodified: no sign handling, rounding or reordering.

Decomposition:
- Shared package holds:
  - SAMPLE_W=16 constant, shared with the FIR filter.
  - sample_t typedef, [0:SAMPLE_W-1].
  - Default CAPTURE_DEPTH=16.
- One sub-module, `sample_ram`:
  - Simple dual-port memory, DEPTH x DATA_W.
  - Synchronous write port (we, waddr, wdata); registered read port (re, raddr, rdata).
  - Allows BRAM/LUTRAM inference.
- Pointers, count, flags and the rd_valid pulse stay in fir_sample_capture.

Test Plan:
- Reset then idle; drive rd_req=1 for 3 cycles.
  - Required: empty=1, count=0, rd_valid never asserts, rd_data=0x0000.
- Write 0x1234, 0xABCD, 0x8001 on consecutive cycles, then rd_req for 3 cycles.
  - Required: rd_valid on 3 consecutive cycles with rd_data 0x1234, 0xABCD, 0x8001; count 3→0; empty=1 at end.
- Write 17 samples 0x0000..0x0010 with no reads (DEPTH=16).
  - Required: full=1 after the 16th; overflow=1 after the 17th.
  - Then 16 reads return 0x0000..0x000F; 0x0010 is never returned.
- With full=1, assert Data_valid=0x5555 and rd_req in the same cycle.
  - Required: overflow stays 0, count stays 16.
  - The read returns the oldest entry; 0x5555 is read last after draining.
- Continuous write+read every cycle for 40 cycles from count=2 (exercises pointer wrap).
  - Required: count constant at 2; output sequence equals input delayed by 2 entries; no overflow.
- Force overflow, then assert clr_ovf coincident with another dropped write.
  - Required: overflow stays 1.
  - Next cycle: clr_ovf alone makes overflow=0.
  - RSTn=0 mid-stream with count=5 gives count=0, empty=1, rd_valid=0 next cycle.
